// File: rtl/jamma_pkg.sv
// Shared types and constants for the JAMMA control reader.
// Scan states, idle vector and player-vector bit positions.
package jamma_pkg;

    typedef enum logic [1:0] {
        SEL1 = 2'd0,
        SMP1 = 2'd1,
        SEL2 = 2'd2,
        SMP2 = 2'd3
    } scan_state_t;

    localparam logic [7:0] JOY_IDLE = 8'hFF;

    localparam int UP    = 0;
    localparam int DOWN  = 1;
    localparam int LEFT  = 2;
    localparam int RIGHT = 3;
    localparam int B1    = 4;
    localparam int B2    = 5;
    localparam int START = 7;

    // Active-low: a pressed on-board control wins over an idle splitter bit.
    function automatic logic [7:0] merge_onboard(
        input logic [7:0] jjoy,
        input logic [5:0] onboard
    );
        return jjoy & {2'b11, onboard};
    endfunction

endpackage

// File: rtl/jamma_input_mux_debounce.sv
// Per-player debounce: output follows a sample only after it has
// been seen on DEBOUNCE consecutive sample strobes.
module jamma_debounce
    import jamma_pkg::*;
#(
    parameter int DEBOUNCE = 4
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_strobe,
    input  logic [7:0] i_sample,
    output logic [7:0] o_vec
);

    localparam logic [3:0] DB = 4'(DEBOUNCE);

    logic [7:0] r_last;
    logic [3:0] r_count;
    logic [7:0] r_vec;
    logic       w_match;
    logic [3:0] w_count_nxt;

    always_comb begin
        w_match     = (i_sample == r_last);
        w_count_nxt = 4'd1;
        if (w_match) begin
            w_count_nxt = (r_count >= DB) ? DB : r_count + 4'd1;
        end
    end

    // The output is updated on the same edge that records the sample.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_last  <= JOY_IDLE;
            r_count <= 4'd0;
            r_vec   <= JOY_IDLE;
        end else if (i_strobe) begin
            r_last  <= i_sample;
            r_count <= w_count_nxt;
            if (w_count_nxt == DB) begin
                r_vec <= i_sample;
            end
        end
    end

    assign o_vec = r_vec;

endmodule

// File: rtl/jamma_input_mux.sv
// Time-multiplexed JAMMA splitter reader: select/settle/sample scan,
// per-player debounce and coin pulse stretching. All controls active-low.
module jamma_input_mux
    import jamma_pkg::*;
#(
    parameter int          SETTLE       = 8,
    parameter int          DEBOUNCE     = 4,
    parameter logic [15:0] COIN_STRETCH = 16'd50000
) (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] JJOY,
    input  logic [5:0] JOYSTICK,
    input  logic [1:0] JCOIN,
    output logic       JSELECT,
    output logic [7:0] joystick1,
    output logic [7:0] joystick2,
    output logic [1:0] coin,
    output logic       scan_tick
);

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE - 1);

    logic [7:0]  r_jjoy_m, r_jjoy_s;
    logic [5:0]  r_onb_m, r_onb_s;
    logic [1:0]  r_coin_m, r_coin_s, r_coin_d;

    scan_state_t r_state, w_state_nxt;
    logic [7:0]  r_settle;
    logic        r_scan_tick;
    logic        w_strobe1, w_strobe2;
    logic [7:0]  w_sample1;

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_jjoy_m <= '1;
            r_jjoy_s <= '1;
            r_onb_m  <= '1;
            r_onb_s  <= '1;
            r_coin_m <= '1;
            r_coin_s <= '1;
            r_coin_d <= '1;
        end else begin
            r_jjoy_m <= JJOY;
            r_jjoy_s <= r_jjoy_m;
            r_onb_m  <= JOYSTICK;
            r_onb_s  <= r_onb_m;
            r_coin_m <= JCOIN;
            r_coin_s <= r_coin_m;
            r_coin_d <= r_coin_s;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_strobe1   = 1'b0;
        w_strobe2   = 1'b0;
        unique case (r_state)
            SEL1: begin
                if (r_settle == SETTLE_LAST) begin
                    w_state_nxt = SMP1;
                end
            end
            SMP1: begin
                w_strobe1   = 1'b1;
                w_state_nxt = SEL2;
            end
            SEL2: begin
                if (r_settle == SETTLE_LAST) begin
                    w_state_nxt = SMP2;
                end
            end
            SMP2: begin
                w_strobe2   = 1'b1;
                w_state_nxt = SEL1;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (reset) begin
            r_state     <= SEL1;
            r_settle    <= 8'd0;
            r_scan_tick <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_settle    <= (w_state_nxt != r_state) ? 8'd0 : r_settle + 8'd1;
            r_scan_tick <= w_strobe2;
        end
    end

    assign JSELECT   = (r_state == SEL2) || (r_state == SMP2);
    assign scan_tick = r_scan_tick;
    assign w_sample1 = merge_onboard(r_jjoy_s, r_onb_s);

    jamma_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_p1 (
        .i_clk    (pclk),
        .i_reset  (reset),
        .i_strobe (w_strobe1),
        .i_sample (w_sample1),
        .o_vec    (joystick1)
    );

    jamma_debounce #(.DEBOUNCE(DEBOUNCE)) u_deb_p2 (
        .i_clk    (pclk),
        .i_reset  (reset),
        .i_strobe (w_strobe2),
        .i_sample (r_jjoy_s),
        .o_vec    (joystick2)
    );

    for (genvar gi = 0; gi < 2; gi++) begin : g_coin
        logic [15:0] r_cnt;
        logic        r_out;
        logic        w_fall;
        logic [15:0] w_cnt_nxt;

        always_comb begin
            w_fall    = r_coin_d[gi] & ~r_coin_s[gi];
            w_cnt_nxt = 16'd0;
            if (w_fall) begin
                w_cnt_nxt = COIN_STRETCH;
            end else if (r_cnt != 16'd0) begin
                w_cnt_nxt = r_cnt - 16'd1;
            end
        end

        // Low while the switch is held or the stretch is still running.
        always_ff @(posedge pclk) begin
            if (reset) begin
                r_cnt <= 16'd0;
                r_out <= 1'b1;
            end else begin
                r_cnt <= w_cnt_nxt;
                r_out <= r_coin_s[gi] & (w_cnt_nxt == 16'd0);
            end
        end

        assign coin[gi] = r_out;
    end

endmodule
